alu4_arb: RTL
=============

# alu4_arb

Two-port arbiter and result register for the shared 4-bit ALU (`alu4`). It accepts operation requests from two independent requesters over valid/ready handshakes and grants one per cycle. It drives the single `alu4` instance it contains and captures the result into a one-entry response register tagged with the requester ID. It sits between the datapath front-ends that need ALU service and the single ALU, so no requester drives `alu4` directly.

## Interface
Parameters:
- none; operand width is fixed at 4 and opcode width at 3 to match `alu4`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req0_valid`  in  1  requester 0 has an operation pending
- `req0_ready`  out  1  requester 0 operation accepted this cycle when `req0_valid` is also high
- `req0_a`, `req0_b`  in  4 each  requester 0 operands
- `req0_opt`  in  3  requester 0 opcode
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_opt`  same widths and meanings for requester 1
- `resp_valid`  out  1  response register holds an unconsumed result
- `resp_ready`  in  1  consumer takes the response this cycle
- `resp_id`  out  1  requester that issued the response (0 or 1)
- `resp_y`  out  4  ALU result

## Operation
- Opcode semantics, implemented by `alu4`:
  - 000 a+b mod 16
  - 001 a-b mod 16
  - 010 ~a
  - 011 a&b
  - 100 a|b
  - 101 a^b
  - 110 {000, signed a<b}
  - 111 {000, a==b}
- Slot free: `free = !resp_valid || resp_ready`.
- Grant is combinational and issued only when `free`.
  - One valid: that requester is granted.
  - Both valid: winner is chosen per Configuration.
- `reqN_ready = free && grant==N`.
  - `ready` never depends on the requester's own `valid` beyond grant selection.
  - The non-granted requester sees `ready=0`.
- The granted request's a/b/opt are muxed onto the `alu4` inputs.
- Capture on accept (`reqN_valid && reqN_ready`): `resp_y <= alu y`, `resp_id <= N`, `resp_valid <= 1`.
- Consume without accept (`resp_valid && resp_ready`, no accept): `resp_valid <= 0`. `resp_y`/`resp_id` hold their last values.
- Consume and accept in the same cycle: the new result replaces the old one and `resp_valid` stays 1 (back-to-back throughput).
- Requesters must hold a/b/opt stable while `valid && !ready`. The arbiter does not latch operands before grant.
- Round-robin pointer `last_id` records the most recently granted requester. It updates only on accept.

## Timing
- Reset values: `resp_valid=0`, `resp_id=0`, `resp_y=4'h0`, `last_id=1` (requester 0 wins the first contention).
- Latency: a request accepted in cycle N has its result on `resp_*` from cycle N+1.
- Throughput: one operation per cycle while `resp_ready=1`.
- Stall: `resp_valid=1 && resp_ready=0` forces both readys low. `resp_*` hold until consumed.
- Reset asserted mid-operation: on the next edge the pending response is discarded, the pointer resets, and both readys are 0 during the reset cycle.

## Configuration
- `ALU4_ARB_RR_EN` defined: round-robin on contention. The requester not in `last_id` wins, so under continuous contention the grants alternate 0,1,0,1.
- Not defined: fixed priority. Requester 0 always wins on contention and `last_id` is not implemented. Requester 1 is served only when `req0_valid=0`.

## Test plan
- Single op: `req0` a=4'h7, b=4'h3, opt=000 with `resp_ready=1` -> `req0_ready=1` same cycle; next cycle `resp_valid=1`, `resp_id=0`, `resp_y=4'hA`.
- Signed compare and equality: `req1` a=4'hF, b=4'h1, opt=110 -> `resp_y=4'h1`, `resp_id=1`; then a=4'h5, b=4'h5, opt=111 -> `resp_y=4'h1`.
- Contention, RR build: both valid for 4 cycles, `resp_ready=1` -> grants 0,1,0,1. Without the macro -> 0,0,0,0 and `req1_ready` stays 0.
- Backpressure: accept opt=001, a=4'h2, b=4'h5 (`resp_y=4'hD`), then `resp_ready=0` for 3 cycles -> both readys 0 and `resp_y` holds 4'hD; when `resp_ready` rises, a new accept occurs in the same cycle and `resp_valid` stays 1.
- Reset mid-stall: `resp_valid=1`, assert `rst` for one cycle -> next cycle `resp_valid=0`, `resp_y=0`, `resp_id=0`; first contention afterwards grants requester 0.
- Idle: no valids for 5 cycles after a consume -> `resp_valid=0` and `resp_y` unchanged.

Source files
------------

// File: rtl/alu4_arb.sv
// Two-requester arbiter in front of one shared 4-bit ALU, with a one-entry tagged result register.
// Define ALU4_ARB_RR_EN for round-robin contention resolution; otherwise requester 0 has fixed priority.

module alu4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] opt,
  output logic [3:0] y
);

  always_comb begin
    y = 4'h0;
    unique case (opt)
      3'b000: y = a + b;
      3'b001: y = a - b;
      3'b010: y = ~a;
      3'b011: y = a & b;
      3'b100: y = a | b;
      3'b101: y = a ^ b;
      3'b110: y = {3'b000, ($signed(a) < $signed(b))};
      3'b111: y = {3'b000, (a == b)};
      default: y = 4'h0;
    endcase
  end

endmodule

module alu4_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_opt,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_opt,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [3:0] resp_y
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Requesters hold operands stable while valid && !ready; resp_* hold while resp_valid && !resp_ready.
  logic       free;
  logic       pick1;
  logic       acc0;
  logic       acc1;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opt;
  logic [3:0] alu_y;

  assign free = !resp_valid || resp_ready;

`ifdef ALU4_ARB_RR_EN
  logic last_id;

  // On contention the requester that was not granted most recently wins.
  assign pick1 = req1_valid && (!req0_valid || !last_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= 1'b1;
    end else if (acc0 || acc1) begin
      last_id <= acc1;
    end
  end
`else
  assign pick1 = req1_valid && !req0_valid;
`endif

  assign req0_ready = !rst && free && req0_valid && !pick1;
  assign req1_ready = !rst && free && pick1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  assign alu_a   = pick1 ? req1_a   : req0_a;
  assign alu_b   = pick1 ? req1_b   : req0_b;
  assign alu_opt = pick1 ? req1_opt : req0_opt;

  alu4 u_alu4 (
    .a   (alu_a),
    .b   (alu_b),
    .opt (alu_opt),
    .y   (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_y     <= 4'h0;
    end else if (acc0 || acc1) begin
      resp_valid <= 1'b1;
      resp_id    <= acc1;
      resp_y     <= alu_y;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
